// File: rtl/apb_m.sv
// APB requester: one valid/ready command becomes SETUP + ACCESS, 3 cycles minimum plus wait states.
// A pending response stalls cmd_ready until rsp_ready accepts it; a silent completer is cut off by TIMEOUT.
module apb_m #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic [ADDR_W-1:0] paddr,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   // A zero TIMEOUT still needs a legal 1-bit counter; it is simply never compared.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              psel_nxt, penable_nxt, pwrite_nxt;
   logic [ADDR_W-1:0] paddr_nxt;
   logic [DATA_W-1:0] pwdata_nxt;
   logic              rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
   logic [DATA_W-1:0] rsp_rdata_nxt;

   assign cmd_ready = (state == IDLE) && !rsp_valid;

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state       <= IDLE;
         cnt         <= '0;
         psel        <= 1'b0;
         penable     <= 1'b0;
         pwrite      <= 1'b0;
         paddr       <= '0;
         pwdata      <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         psel        <= psel_nxt;
         penable     <= penable_nxt;
         pwrite      <= pwrite_nxt;
         paddr       <= paddr_nxt;
         pwdata      <= pwdata_nxt;
         rsp_valid   <= rsp_valid_nxt;
         rsp_rdata   <= rsp_rdata_nxt;
         rsp_err     <= rsp_err_nxt;
         rsp_timeout <= rsp_timeout_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      psel_nxt        = psel;
      penable_nxt     = penable;
      pwrite_nxt      = pwrite;
      paddr_nxt       = paddr;
      pwdata_nxt      = pwdata;
      rsp_valid_nxt   = rsp_valid;
      rsp_rdata_nxt   = rsp_rdata;
      rsp_err_nxt     = rsp_err;
      rsp_timeout_nxt = rsp_timeout;

      if (rsp_valid && rsp_ready)
         rsp_valid_nxt = 1'b0;

      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               pwrite_nxt  = cmd_write;
               paddr_nxt   = cmd_addr;
               pwdata_nxt  = cmd_wdata;
               psel_nxt    = 1'b1;
               penable_nxt = 1'b0;
               state_nxt   = SETUP;
            end
         end
         SETUP: begin
            penable_nxt = 1'b1;
            cnt_nxt     = '0;
            state_nxt   = ACCESS;
         end
         ACCESS: begin
            // pready takes priority over a timeout landing on the same cycle.
            if (pready) begin
               rsp_valid_nxt   = 1'b1;
               rsp_err_nxt     = pslverr;
               rsp_timeout_nxt = 1'b0;
               rsp_rdata_nxt   = (!pwrite && !pslverr) ? prdata : '0;
               psel_nxt        = 1'b0;
               penable_nxt     = 1'b0;
               state_nxt       = IDLE;
            end else begin
               if (cnt != {CNT_W{1'b1}})
                  cnt_nxt = cnt + CNT_W'(1);
               if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                  rsp_valid_nxt   = 1'b1;
                  rsp_err_nxt     = 1'b1;
                  rsp_timeout_nxt = 1'b1;
                  rsp_rdata_nxt   = '0;
                  psel_nxt        = 1'b0;
                  penable_nxt     = 1'b0;
                  state_nxt       = IDLE;
               end
            end
         end
         default: begin
            psel_nxt    = 1'b0;
            penable_nxt = 1'b0;
            state_nxt   = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_apb_m.sv
// Directed bench for apb_m against a 16-entry APB completer model with programmable wait states.
module tb_apb_m;

   logic        pclk = 1'b0;
   logic        preset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [7:0]  rsp_rdata;
   logic [31:0] paddr;
   logic        psel, penable, pwrite;
   logic [7:0]  pwdata, prdata;
   logic        pready, pslverr;

   int nvec = 0;
   int nerr = 0;

   // completer model controls
   logic       hang = 1'b0;
   int         wait_n = 0;
   int         acc_cnt = 0;
   logic [7:0] mem [16];

   // observations from wait_rsp
   int   n_psel, n_pen;
   logic stable;

   apb_m #(.ADDR_W(32), .DATA_W(8), .TIMEOUT(16)) dut (
      .pclk(pclk), .preset(preset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
      .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 pclk = ~pclk;

   assign pready  = psel && penable && !hang && (acc_cnt >= wait_n);
   assign pslverr = psel && penable && (paddr >= 32'd16);
   assign prdata  = mem[paddr[3:0]];

   always @(posedge pclk) begin
      if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
      else                            acc_cnt <= 0;
      if (psel && penable && pready && pwrite && !pslverr)
         mem[paddr[3:0]] <= pwdata;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns just after the accepting edge with cmd_* scrambled.
   task automatic issue(input logic w, input logic [31:0] a, input logic [7:0] d);
      int g;
      g = 0;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      while (!cmd_ready && g < 50) begin
         @(negedge pclk);
         g++;
      end
      chk("cmd_accept", cmd_ready, 1);
      @(posedge pclk);
      #1;
      cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = 32'hFFFF_FFF0; cmd_wdata = ~d;
   endtask

   task automatic wait_rsp(input logic w, input logic [31:0] a, input logic [7:0] d);
      int g;
      g = 0;
      n_psel = 0; n_pen = 0; stable = 1'b1;
      while (!rsp_valid && g < 200) begin
         @(negedge pclk);
         if (psel)    n_psel++;
         if (penable) n_pen++;
         if (psel && (paddr !== a || pwrite !== w || (w && pwdata !== d))) stable = 1'b0;
         g++;
      end
      chk("rsp_arrives", rsp_valid, 1);
   endtask

   task automatic take_rsp;
      rsp_ready = 1'b1;
      @(negedge pclk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0;
      repeat (2) @(negedge pclk);
      chk("rst_psel", psel, 0);
      chk("rst_penable", penable, 0);
      chk("rst_pwrite", pwrite, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_pwdata", pwdata, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_timeout", rsp_timeout, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      preset = 1'b0;
      @(negedge pclk);

      // 1: zero-wait write
      issue(1'b1, 32'd3, 8'hA5);
      wait_rsp(1'b1, 32'd3, 8'hA5);
      chk("t1_psel_cycles", n_psel, 2);
      chk("t1_penable_cycles", n_pen, 1);
      chk("t1_err", rsp_err, 0);
      chk("t1_rdata", rsp_rdata, 8'h00);
      chk("t1_stable", stable, 1);
      take_rsp();

      // 2: read back
      issue(1'b0, 32'd3, 8'h00);
      wait_rsp(1'b0, 32'd3, 8'h00);
      chk("t2_rdata", rsp_rdata, 8'hA5);
      chk("t2_err", rsp_err, 0);
      chk("t2_addr_stable", stable, 1);
      chk("t2_penable_cycles", n_pen, 1);
      take_rsp();

      // 3: slave error on out-of-range read
      issue(1'b0, 32'h20, 8'h00);
      wait_rsp(1'b0, 32'h20, 8'h00);
      chk("t3_err", rsp_err, 1);
      chk("t3_timeout", rsp_timeout, 0);
      chk("t3_rdata", rsp_rdata, 8'h00);
      take_rsp();

      // 4a: four wait states
      wait_n = 4;
      issue(1'b1, 32'd7, 8'h3C);
      wait_rsp(1'b1, 32'd7, 8'h3C);
      chk("t4a_access_cycles", n_pen, 5);
      chk("t4a_err", rsp_err, 0);
      chk("t4a_stable", stable, 1);
      take_rsp();

      // 4b: completer never answers
      hang = 1'b1;
      issue(1'b1, 32'd8, 8'h11);
      wait_rsp(1'b1, 32'd8, 8'h11);
      chk("t4b_access_cycles", n_pen, 16);
      chk("t4b_err", rsp_err, 1);
      chk("t4b_timeout", rsp_timeout, 1);
      chk("t4b_rdata", rsp_rdata, 8'h00);
      chk("t4b_psel", psel, 0);
      take_rsp();
      hang = 1'b0;

      // 4c: pready on the very cycle the timeout would fire
      wait_n = 15;
      issue(1'b0, 32'd7, 8'h00);
      wait_rsp(1'b0, 32'd7, 8'h00);
      chk("t4c_access_cycles", n_pen, 16);
      chk("t4c_err", rsp_err, 0);
      chk("t4c_timeout", rsp_timeout, 0);
      chk("t4c_rdata", rsp_rdata, 8'h3C);
      take_rsp();
      wait_n = 0;

      // 5: response backpressure with a command waiting
      issue(1'b1, 32'd5, 8'h5A);
      wait_rsp(1'b1, 32'd5, 8'h5A);
      take_rsp();
      issue(1'b0, 32'd5, 8'h00);
      wait_rsp(1'b0, 32'd5, 8'h00);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'd3; cmd_wdata = 8'h00;
      for (int i = 0; i < 10; i++) begin
         @(negedge pclk);
         chk("t5_cmd_ready_blocked", cmd_ready, 0);
         chk("t5_rdata_held", rsp_rdata, 8'h5A);
         chk("t5_rsp_valid_held", rsp_valid, 1);
      end
      take_rsp();
      chk("t5_rsp_cleared", rsp_valid, 0);
      chk("t5_cmd_ready", cmd_ready, 1);
      @(posedge pclk);
      #1;
      cmd_valid = 1'b0; cmd_addr = 32'hFFFF_FFF0;
      chk("t5_next_accepted", psel, 1);
      wait_rsp(1'b0, 32'd3, 8'h00);
      chk("t5_next_rdata", rsp_rdata, 8'hA5);
      take_rsp();

      // 6: reset in the middle of a stalled ACCESS
      hang = 1'b1;
      issue(1'b0, 32'd4, 8'h00);
      repeat (2) @(negedge pclk);
      chk("t6_in_access", penable, 1);
      #2 preset = 1'b1;
      #1;
      chk("t6_psel_async", psel, 0);
      chk("t6_penable_async", penable, 0);
      chk("t6_rsp_valid_async", rsp_valid, 0);
      @(negedge pclk);
      preset = 1'b0;
      hang = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge pclk);
         chk("t6_no_stale_rsp", rsp_valid, 0);
         chk("t6_cmd_ready", cmd_ready, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/apb_m.md
Name: apb_m

Overview:
APB requester (master) that drives the `apb_s` completer and any other 8-bit APB completer in the subsystem. It accepts single read/write commands on a valid/ready command port and sequences them through the APB SETUP and ACCESS phases. It returns read data and error status on a valid/ready response port. A programmable ACCESS-phase timeout stops a missing `pready` from hanging the bus.

Parameters:
ADDR_W, 32, width of `cmd_addr`/`paddr`
DATA_W, 8, width of write/read data
TIMEOUT, 16, max ACCESS cycles waiting for `pready`; 0 disables timeout

Ports:
pclk  in  1  APB clock; all logic on rising edge
preset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  block can accept command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  transfer address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  DATA_W  read data; 0 for writes and errored reads
rsp_err  out  1  `pslverr` seen or timeout
rsp_timeout  out  1  error was a timeout
paddr  out  ADDR_W  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB error

Behaviour:
- Reset (async, while `preset`=1): state=IDLE. `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `rsp_timeout` and the timeout counter are all 0.
- All APB outputs and response outputs are registered. `cmd_ready` is combinational: 1 when state==IDLE and `rsp_valid`==0.
- States and transitions:
  - IDLE: on `cmd_valid` && `cmd_ready`, latch `cmd_write`/`cmd_addr`/`cmd_wdata` into `pwrite`/`paddr`/`pwdata`, set `psel`=1, `penable`=0, go to SETUP.
  - SETUP: lasts exactly 1 cycle. Set `penable`=1, clear the counter, go to ACCESS.
  - ACCESS: `psel`=`penable`=1. The counter increments each cycle `pready`=0.
    - If `pready`=1: `rsp_valid`=1, `rsp_err`=`pslverr`, `rsp_timeout`=0, `rsp_rdata`=`prdata` when (!`pwrite` && !`pslverr`), else 0. Drop `psel`/`penable`, go to IDLE.
    - Else if TIMEOUT≠0 and counter==TIMEOUT-1: `rsp_valid`=1, `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0. Drop `psel`/`penable`, go to IDLE.
    - A `pready` in the same cycle the timeout would fire wins: the transfer completes normally.
- `paddr`, `pwrite`, `pwdata` are stable from SETUP through the last ACCESS cycle. In IDLE they hold their last values.
- Response handshake: `rsp_valid` holds, with all response fields stable, until `rsp_valid` && `rsp_ready`, then clears next edge. No new command is accepted while a response is pending.
- Minimum cost per transfer is 3 cycles (IDLE accept, SETUP, ACCESS with `pready`=1), plus 1 per wait state. There is no back-to-back SETUP.
- `cmd_*` inputs are ignored outside the accept cycle.
- `prdata`/`pslverr` are sampled only in the ACCESS cycle where `pready`=1.
- Reset mid-transfer: `psel`/`penable` drop immediately (async), the in-flight command is discarded, and no response is produced.
- Timeout counter width is clog2(TIMEOUT+1). It saturates and never wraps.

Test Plan:
1. Write `cmd_addr`=3, `cmd_wdata`=0xA5 to a 16-entry completer with `pready` in the first ACCESS cycle → `psel`=1 for exactly 2 cycles, `penable`=1 for 1. Then `rsp_valid`=1, `rsp_err`=0, `rsp_rdata`=0x00.
2. Read `cmd_addr`=3 after test 1 → `rsp_rdata`=0xA5, `rsp_err`=0. `paddr`=3 and `pwrite`=0 stable across SETUP/ACCESS.
3. Read `cmd_addr`=0x20 with the completer asserting `pslverr` → `rsp_err`=1, `rsp_timeout`=0, `rsp_rdata`=0x00.
4. Write with `pready` delayed 4 ACCESS cycles (TIMEOUT=16) → ACCESS lasts 5 cycles, `rsp_err`=0. With `pready` held 0 instead → exactly 16 ACCESS cycles, then `rsp_err`=1, `rsp_timeout`=1, `psel`=0.
5. Hold `rsp_ready`=0 for 10 cycles after a read of 0x5A while `cmd_valid`=1 → `cmd_ready`=0 throughout, `rsp_rdata` stays 0x5A. The next command is accepted the cycle after the `rsp_ready` handshake.
6. Assert `preset` during ACCESS with `pready`=0 → `psel`/`penable`/`rsp_valid` are 0 before the next `pclk` edge. After release, `cmd_ready`=1 and no stale response appears.
